// File: rtl/mux_2_1_arbiter.sv
// ---------------------------------------------------------------------------
// mux_2_1_arbiter
//
// Two-requester arbiter that shares one 2:1 mux datapath between requester A
// (mux input a) and requester B (mux input b). It drives the mux select, the
// per-requester grants, and a valid/ready handshake toward one downstream
// consumer. A hold counter bounds the number of accepted beats per grant, so
// neither requester can starve the other.
//
// Default build: round-robin. When both sides request in IDLE, the side that
// was not served last wins. A grant is forced over to the other side after
// MAX_HOLD accepted beats, but only while that side is requesting.
//
// Optional feature, macro ARB_PRIORITY_A_EN: fixed priority to A. IDLE
// contention always grants A. OWN_A is released only when req_a drops.
// OWN_B is still forced back to A by the hold limit.
//
// Parameters:
//   WIDTH     data width of a, b, out
//   MAX_HOLD  beats per grant before forced rotation (1..255)
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset
//   req_a  in   requester A wants the datapath
//   req_b  in   requester B wants the datapath
//   a      in   data from requester A
//   b      in   data from requester B
//   ready  in   downstream accepts the current beat
//   gnt_a  out  A owns the datapath
//   gnt_b  out  B owns the datapath
//   s      out  mux select, 0 = a, 1 = b
//   out    out  muxed data (combinational, s ? b : a)
//   valid  out  out carries a beat from the owner
// ---------------------------------------------------------------------------
module mux_2_1_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ready,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             s,
    output logic [WIDTH-1:0] out,
    output logic             valid
);

    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_hold_cnt;
    logic [CW-1:0]   w_hold_cnt_nxt;
    logic            r_gnt_a;
    logic            r_gnt_b;
    logic            r_sel;
    logic            w_beat;
    logic            w_hold_last;
    logic            w_idle_pick_b;
    logic            w_rot_from_a;
    logic            w_rot_from_b;

    // The beat that takes the count to MAX_HOLD is the one that rotates.
    // A saturated count keeps this true, so a late request from the other
    // side rotates on its first accepted beat.
    assign w_beat      = valid & ready;
    assign w_hold_last = (r_hold_cnt >= HOLD_LAST);
    assign w_rot_from_b = w_beat & req_a & w_hold_last;

`ifdef ARB_PRIORITY_A_EN
    assign w_idle_pick_b = 1'b0;
    assign w_rot_from_a  = 1'b0;
`else
    logic r_last_b;

    // Remember which side gave up the datapath most recently. Reset to B so
    // that A wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_b <= 1'b1;
        end else if ((r_state == OWN_A) && (w_state_nxt != OWN_A)) begin
            r_last_b <= 1'b0;
        end else if ((r_state == OWN_B) && (w_state_nxt != OWN_B)) begin
            r_last_b <= 1'b1;
        end else begin
            r_last_b <= r_last_b;
        end
    end

    assign w_idle_pick_b = ~r_last_b;
    assign w_rot_from_a  = w_beat & req_b & w_hold_last;
`endif

    // Next-state selection for the ownership FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_a && req_b) begin
                    w_state_nxt = w_idle_pick_b ? OWN_B : OWN_A;
                end else if (req_a) begin
                    w_state_nxt = OWN_A;
                end else if (req_b) begin
                    w_state_nxt = OWN_B;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    w_state_nxt = req_b ? OWN_B : IDLE;
                end else if (w_rot_from_a) begin
                    w_state_nxt = OWN_B;
                end else begin
                    w_state_nxt = OWN_A;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    w_state_nxt = req_a ? OWN_A : IDLE;
                end else if (w_rot_from_b) begin
                    w_state_nxt = OWN_A;
                end else begin
                    w_state_nxt = OWN_B;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Hold counter: clears on any ownership change and counts accepted beats,
    // saturating at MAX_HOLD. Stalled cycles leave it frozen.
    always_comb begin
        w_hold_cnt_nxt = r_hold_cnt;
        if (w_state_nxt != r_state) begin
            w_hold_cnt_nxt = {CW{1'b0}};
        end else if (w_beat && (r_hold_cnt != HOLD_MAX)) begin
            w_hold_cnt_nxt = r_hold_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_hold_cnt_nxt = r_hold_cnt;
        end
    end

    // State, counter and grant/select flops. Grants are loaded from the next
    // state, so they always match the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= {CW{1'b0}};
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_sel      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gnt_a    <= (w_state_nxt == OWN_A);
            r_gnt_b    <= (w_state_nxt == OWN_B);
            r_sel      <= (w_state_nxt == OWN_B);
        end
    end

    assign gnt_a = r_gnt_a;
    assign gnt_b = r_gnt_b;
    assign s     = r_sel;
    assign valid = (r_gnt_a & req_a) | (r_gnt_b & req_b);
    assign out   = r_sel ? b : a;

endmodule

// File: tb/tb_mux_2_1_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_2_1_arbiter
//
// Scenario tasks for mux_2_1_arbiter (WIDTH = 8, MAX_HOLD = 4). Each cycle
// the bench pushes the expected {gnt_a, gnt_b, s, valid, out}. It then drives
// the inputs and pops the expected value at the falling edge to compare it.
// Build with ARB_PRIORITY_A_EN defined to exercise fixed-priority mode.
// ---------------------------------------------------------------------------
module tb_mux_2_1_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       ready = 1'b0;
    logic       gnt_a;
    logic       gnt_b;
    logic       s;
    logic [7:0] out;
    logic       valid;

    typedef struct packed {
        logic       ga;
        logic       gb;
        logic       s;
        logic       v;
        logic [7:0] o;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mux_2_1_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req_a (req_a),
        .req_b (req_b),
        .a     (a),
        .b     (b),
        .ready (ready),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .s     (s),
        .out   (out),
        .valid (valid)
    );

    always #5 clk = ~clk;

    // Drive one cycle: apply {rst, req_a, req_b, ready} just after the rising
    // edge and return at the falling edge, where the outputs are sampled.
    task automatic cyc(input logic [3:0] st, input logic [7:0] da, input logic [7:0] db);
        @(posedge clk);
        #1;
        rst   = st[3];
        req_a = st[2];
        req_b = st[1];
        ready = st[0];
        a     = da;
        b     = db;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] st [4];
        logic [3:0] ex [4];
        exp_t e;
        exp_t obs;
        st = '{4'b1111, 4'b1111, 4'b0111, 4'b0111};
        ex = '{4'b0000, 4'b0000, 4'b0000, 4'b1001};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{ex[i][3], ex[i][2], ex[i][1], ex[i][0], (ex[i][1] ? 8'h22 : 8'h11)});
            cyc(st[i], 8'h11, 8'h22);
            e   = sb_q.pop_front();
            obs = '{gnt_a, gnt_b, s, valid, out};
            n_checks++;
            if (obs !== e) $display("FAIL reset step%0d: got ga/gb/s/v/out=%h want %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        logic [3:0] ex;
        exp_t e;
        exp_t obs;
        cyc(4'b1001, 8'h3C, 8'h55);
        for (int i = 0; i < 13; i++) begin
            if (i == 0) ex = 4'b0000;
`ifdef ARB_PRIORITY_A_EN
            else ex = 4'b1001;
`else
            else if (i == 12) ex = 4'b0111;
            else ex = 4'b1001;
`endif
            sb_q.push_back('{ex[3], ex[2], ex[1], ex[0], (ex[1] ? 8'h55 : 8'h3C)});
            cyc((i >= 11) ? 4'b0111 : 4'b0101, 8'h3C, 8'h55);
            e   = sb_q.pop_front();
            obs = '{gnt_a, gnt_b, s, valid, out};
            n_checks++;
            if (obs !== e) $display("FAIL single step%0d: got ga/gb/s/v/out=%h want %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_contention();
        logic [3:0] ex;
        logic [7:0] da;
        logic [7:0] db;
        logic       ob;
        exp_t e;
        exp_t obs;
        cyc(4'b1001, 8'h00, 8'h00);
        for (int i = 0; i < 17; i++) begin
            da = 8'(i);
            db = 8'h80 | 8'(i);
            ob = (((i - 1) / 4) % 2) == 1;
            ex = (i == 0) ? 4'b0000 : {~ob, ob, ob, 1'b1};
            sb_q.push_back('{ex[3], ex[2], ex[1], ex[0], (ex[1] ? db : da)});
            cyc(4'b0111, da, db);
            e   = sb_q.pop_front();
            obs = '{gnt_a, gnt_b, s, valid, out};
            n_checks++;
            if (obs !== e) $display("FAIL contention step%0d: got ga/gb/s/v/out=%h want %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] st [13];
        logic [3:0] ex [13];
        exp_t e;
        exp_t obs;
        st = '{4'b0011, 4'b0111, 4'b0111, 4'b0110, 4'b0110, 4'b0110, 4'b0110,
               4'b0110, 4'b0111, 4'b0111, 4'b0111, 4'b1110, 4'b0000};
        ex = '{4'b0000, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111,
               4'b0111, 4'b0111, 4'b0111, 4'b1001, 4'b1001, 4'b0000};
        cyc(4'b1001, 8'hAA, 8'hBB);
        for (int i = 0; i < 13; i++) begin
            sb_q.push_back('{ex[i][3], ex[i][2], ex[i][1], ex[i][0], (ex[i][1] ? 8'hBB : 8'hAA)});
            cyc(st[i], 8'hAA, 8'hBB);
            e   = sb_q.pop_front();
            obs = '{gnt_a, gnt_b, s, valid, out};
            n_checks++;
            if (obs !== e) $display("FAIL backpressure step%0d: got ga/gb/s/v/out=%h want %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_release();
        logic [3:0] st [10];
        logic [3:0] ex [10];
        int   n;
        exp_t e;
        exp_t obs;
        st = '{4'b0101, 4'b0101, 4'b0011, 4'b0011, 4'b0001,
               4'b0001, 4'b0101, 4'b0001, 4'b0111, 4'b0111};
        ex = '{4'b0000, 4'b1001, 4'b1000, 4'b0111, 4'b0110,
               4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0111};
`ifdef ARB_PRIORITY_A_EN
        n = 6;
`else
        n = 10;
`endif
        cyc(4'b1001, 8'hC1, 8'hD2);
        for (int i = 0; i < n; i++) begin
            sb_q.push_back('{ex[i][3], ex[i][2], ex[i][1], ex[i][0], (ex[i][1] ? 8'hD2 : 8'hC1)});
            cyc(st[i], 8'hC1, 8'hD2);
            e   = sb_q.pop_front();
            obs = '{gnt_a, gnt_b, s, valid, out};
            n_checks++;
            if (obs !== e) $display("FAIL release step%0d: got ga/gb/s/v/out=%h want %h", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        logic [3:0] st;
        logic [3:0] ex;
        exp_t e;
        exp_t obs;
        cyc(4'b1001, 8'hE1, 8'hF2);
        for (int i = 0; i < 19; i++) begin
            st = (i == 13) ? 4'b0011 : 4'b0111;
            if (i == 0) ex = 4'b0000;
            else if (i == 13) ex = 4'b1000;
            else if (i >= 14 && i <= 17) ex = 4'b0111;
            else ex = 4'b1001;
            sb_q.push_back('{ex[3], ex[2], ex[1], ex[0], (ex[1] ? 8'hF2 : 8'hE1)});
            cyc(st, 8'hE1, 8'hF2);
            e   = sb_q.pop_front();
            obs = '{gnt_a, gnt_b, s, valid, out};
            n_checks++;
            if (obs !== e) $display("FAIL priority step%0d: got ga/gb/s/v/out=%h want %h", i, obs, e);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
`ifdef ARB_PRIORITY_A_EN
        test_priority();
`else
        test_contention();
`endif
        test_backpressure();
        test_release();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_2_1_arbiter.md
Name: mux_2_1_arbiter

Overview:
- Two-requester round-robin arbiter that shares one 2:1 mux datapath, with requester A on mux input a and requester B on input b.
- Drives the mux select, per-requester grants, and a valid/ready handshake toward a single downstream consumer.
- Enforces a bounded hold per grant so neither requester can starve the other.
- Sits between two producer blocks and one consumer in the datapath layer.

Parameters:
- WIDTH, 8, data width of a, b, out.
- MAX_HOLD, 4, maximum accepted beats per grant before forced rotation when the other side is requesting; legal range 1..255.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_a  input  1  requester A wants the datapath; held high while it has data.
- req_b  input  1  requester B wants the datapath.
- a  input  WIDTH  data from requester A.
- b  input  WIDTH  data from requester B.
- ready  input  1  downstream accepts the current beat when high.
- gnt_a  output  1  A owns the datapath.
- gnt_b  output  1  B owns the datapath.
- s  output  1  mux select; 0 = a, 1 = b.
- out  output  WIDTH  muxed data, combinational: s ? b : a.
- valid  output  1  out carries a beat from the owner.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. rst is sampled on the rising edge of clk and overrides all other inputs.
- Reset values: state = IDLE, gnt_a = 0, gnt_b = 0, s = 0, valid = 0, hold count = 0, last_served = B (so A wins the first contention). out = a because s = 0.
- FSM states are IDLE, OWN_A, OWN_B. Outputs are Moore on state:
  - gnt_a = (state == OWN_A); gnt_b = (state == OWN_B).
  - s = (state == OWN_B); s = 0 in IDLE.
  - valid = (OWN_A & req_a) | (OWN_B & req_b).
- Beat: valid & ready in a cycle. Beats increment the hold counter (width clog2(MAX_HOLD+1)), saturating at MAX_HOLD. Counter clears on every state change.
- IDLE transitions:
  - Only req_a -> OWN_A.
  - Only req_b -> OWN_B.
  - Both -> the side that is not last_served.
  - Neither -> stay in IDLE.
  - Grant latency is 1 cycle from req seen in IDLE; first valid possible in that grant cycle.
- OWN_X, owner drops req_x: next state is OWN_other if req_other, else IDLE. valid = 0 in the drop cycle.
- OWN_X, forced rotation: a beat that brings the count to MAX_HOLD while req_other = 1 moves the state to OWN_other at that edge, with no idle bubble.
- OWN_X, beat reaches MAX_HOLD and req_other = 0: stay in OWN_X; counter holds at MAX_HOLD. Rotation fires on the first later beat seen while req_other = 1.
- ready low: no beat, counter frozen, grant held. The arbiter never rotates on stalled cycles, so data on out stays stable for the consumer.
- last_served updates to X whenever the state leaves OWN_X.
- rst mid-transfer: returns to IDLE on the next edge regardless of ready. Any in-flight beat not yet accepted is dropped.
- Requester contract: a/b must be stable while own req and gnt are high and ready is low. The block does not check this.

Optional Feature:
- Macro: ARB_PRIORITY_A_EN.
- Defined:
  - Fixed priority to A. IDLE with both requests grants A.
  - OWN_A is never forced off by the hold limit; it releases only when req_a drops.
  - OWN_B is forced to OWN_A after MAX_HOLD beats if req_a = 1, or immediately on any beat while req_a = 1 if MAX_HOLD = 1.
  - last_served is unused.
- Undefined: round-robin behaviour as described above.

Test Plan:
- Reset: assert rst 2 cycles with req_a = req_b = 1 -> gnt_a = gnt_b = s = valid = 0 throughout. First edge after release gives gnt_a = 1, s = 0.
- Single requester: req_a = 1, a = 8'h3C, ready = 1 for 10 cycles, req_b = 0 -> gnt_a stays 1, out = 8'h3C, valid = 1 each cycle, no rotation.
- Contention rotation (MAX_HOLD = 4): req_a = req_b = 1, ready = 1 -> grants follow A,A,A,A,B,B,B,B,A... with s toggling every 4 cycles and no valid = 0 gap at switches.
- Backpressure: OWN_B after 2 beats, ready = 0 for 5 cycles with req_a = 1 -> gnt_b held, valid = 1, out = b stable, counter frozen at 2. Rotation occurs after 2 more accepted beats.
- Release handoff: OWN_A, req_a drops while req_b = 1 -> one cycle with valid = 0, then gnt_b = 1, s = 1. Both requests then dropped -> IDLE, s = 0.
- ARB_PRIORITY_A_EN: both requests continuous, ready = 1 -> gnt_a held indefinitely and gnt_b never asserts. Dropping req_a gives B the grant; re-raising req_a returns the grant to A after MAX_HOLD B beats.
